// File: rtl/host_req_tag_tracker.sv
// Host request tag tracker: allocates host tags to L2 stream requests and maps host responses back to stream IDs.
// Optional HOST_REQ_TAG_CHECK_EN: drop responses for unallocated tags and raise a sticky o_err.
module host_req_tag_tracker #(
   parameter int addr_width   = 64,
   parameter int nstrms       = 64,
   parameter int nstrms_width = $clog2(nstrms),
   parameter int ntags        = 32,
   parameter int tag_width    = $clog2(ntags)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    i_req_v,
   output logic                    i_req_r,
   input  logic [nstrms_width-1:0] i_req_sid,
   input  logic [addr_width-1:0]   i_req_ea,
   output logic                    o_host_v,
   input  logic                    o_host_r,
   output logic [tag_width-1:0]    o_host_tag,
   output logic [addr_width-1:0]   o_host_ea,
   input  logic                    i_host_v,
   output logic                    i_host_r,
   input  logic [tag_width-1:0]    i_host_tag,
   output logic                    o_rsp_v,
   input  logic                    o_rsp_r,
   output logic [nstrms_width-1:0] o_rsp_sid,
   output logic [tag_width:0]      o_cnt,
   output logic                    o_err
);

   localparam int cnt_w = tag_width + 1;

   // Handshakes: a transfer happens in a cycle where valid and ready are both high;
   // valid, once raised, holds with stable payload until the transfer.
   logic [ntags-1:0]        free;
   logic [nstrms_width-1:0] sid_tbl [ntags];
   logic [tag_width-1:0]    alloc_tag;
   logic [ntags-1:0]        alloc_mask;
   logic [ntags-1:0]        rel_mask;
   logic                    any_free;
   logic                    req_fire;
   logic                    host_fire;
   logic                    rel_ok;
   logic                    rsp_load;

   // Lowest-index free tag wins.
   always_comb begin
      alloc_tag = '0;
      for (int i = ntags - 1; i >= 0; i--) begin
         if (free[i]) alloc_tag = tag_width'(i);
      end
   end

   assign any_free  = |free;
   assign i_req_r   = (~o_host_v | o_host_r) & any_free & ~reset;
   assign i_host_r  = ~o_rsp_v | o_rsp_r;
   assign req_fire  = i_req_v & i_req_r;
   assign host_fire = i_host_v & i_host_r;

`ifdef HOST_REQ_TAG_CHECK_EN
   assign rel_ok = ~free[i_host_tag];
`else
   assign rel_ok = 1'b1;
`endif

   assign rsp_load = host_fire & rel_ok;

   always_comb begin
      alloc_mask = '0;
      rel_mask   = '0;
      if (req_fire) alloc_mask[alloc_tag] = 1'b1;
      if (rsp_load) rel_mask[i_host_tag] = 1'b1;
   end

   // Table holds stale entries after reset; only allocated tags are ever read legally.
   always_ff @(posedge clk) begin
      if (req_fire) sid_tbl[alloc_tag] <= i_req_sid;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         free       <= '1;
         o_host_v   <= 1'b0;
         o_host_tag <= '0;
         o_host_ea  <= '0;
         o_rsp_v    <= 1'b0;
         o_rsp_sid  <= '0;
         o_cnt      <= '0;
      end else begin
         // Allocation sees the pre-update free vector, so a tag released this cycle is not reused until the next.
         free <= (free & ~alloc_mask) | rel_mask;

         if (req_fire) begin
            o_host_v   <= 1'b1;
            o_host_tag <= alloc_tag;
            o_host_ea  <= i_req_ea;
         end else if (o_host_r) begin
            o_host_v <= 1'b0;
         end

         if (rsp_load) begin
            o_rsp_v   <= 1'b1;
            o_rsp_sid <= sid_tbl[i_host_tag];
         end else if (o_rsp_r) begin
            o_rsp_v <= 1'b0;
         end

         case ({req_fire, rsp_load})
            2'b10:   o_cnt <= o_cnt + cnt_w'(1);
            2'b01:   o_cnt <= o_cnt - cnt_w'(1);
            default: o_cnt <= o_cnt;
         endcase
      end
   end

`ifdef HOST_REQ_TAG_CHECK_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         o_err <= 1'b0;
      end else if (host_fire & ~rel_ok) begin
         o_err <= 1'b1;
      end
   end
`else
   assign o_err = 1'b0;
`endif

endmodule

// File: doc/host_req_tag_tracker.md
# host_req_tag_tracker

Sits between the L2 controller's host request/response ports and the OpenCAPI 3.0 host interface. Assigns a unique host tag to each stream-ID-tagged cache-line request, bounds the number of requests in flight, and maps out-of-order host responses back to the originating stream ID. Replaces the direct request-to-response loopback used in standalone L2 controller simulation.

## Interface
- `addr_width`, 64: host effective address width in bits.
- `nstrms`, 64: number of streams.
- `nstrms_width`, `$clog2(nstrms)`: stream ID width.
- `ntags`, 32: maximum outstanding host requests; must be a power of two and at least 2.
- `tag_width`, `$clog2(ntags)`: host tag width.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high reset.
- `i_req_v` in 1 / `i_req_r` out 1: request handshake from the L2 controller.
- `i_req_sid` in nstrms_width / `i_req_ea` in addr_width: stream ID and cache-line EA.
- `o_host_v` out 1 / `o_host_r` in 1: request handshake to the host.
- `o_host_tag` out tag_width / `o_host_ea` out addr_width: allocated tag and EA.
- `i_host_v` in 1 / `i_host_r` out 1: response handshake from the host.
- `i_host_tag` in tag_width: tag of the completed request.
- `o_rsp_v` out 1 / `o_rsp_r` in 1: response handshake to the L2 controller.
- `o_rsp_sid` out nstrms_width: stream ID of the completed request.
- `o_cnt` out tag_width+1: number of tags currently allocated.
- `o_err` out 1: sticky error flag for an unallocated response tag.

## Operation
- State:
  - `free[ntags]` bit vector, with all bits set after reset.
  - Tag table `sid_tbl[ntags]` of nstrms_width.
  - One-entry request output register.
  - One-entry response output register.
  - Outstanding counter.
- Request path:
  - `i_req_r = (~o_host_v | o_host_r) & |free & ~reset`.
  - On `i_req_v & i_req_r`:
    - Allocate the lowest-index set bit of `free` and clear it.
    - Write `sid_tbl[tag] = i_req_sid`.
    - Load `{tag, ea}` into the output register and set `o_host_v`.
- `o_host_v` stays asserted with stable tag and EA until `o_host_r`.
- Response path:
  - `i_host_r = ~o_rsp_v | o_rsp_r`.
  - On `i_host_v & i_host_r`:
    - Load `o_rsp_sid = sid_tbl[i_host_tag]` and set `o_rsp_v`.
    - Set `free[i_host_tag]`.
- Freed tag timing: a tag freed in cycle N is visible to allocation in cycle N+1. It is never freed and reallocated in the same cycle.
- `o_cnt`:
  - +1 on allocate, −1 on free, unchanged when both occur in the same cycle.
  - Range 0..ntags.
- Full: when `o_cnt == ntags`, `i_req_r = 0` until a response is accepted.
- Responses may arrive in any order. Each tag is returned exactly once per allocation.

## Timing
- Request latency: 1 cycle, from `i_req` handshake to `o_host_v`.
- Response latency: 1 cycle, from `i_host` handshake to `o_rsp_v`.
- Each path sustains one transfer per cycle under continuous ready.
- Reset values:
  - `o_host_v=0`, `o_rsp_v=0`, `o_cnt=0`, `o_err=0`.
  - `o_host_tag`, `o_host_ea`, `o_rsp_sid` all 0.
  - `i_req_r=0` while `reset` is high.
  - `free` all ones.
- `sid_tbl` is not reset.
- Reset mid-operation:
  - All in-flight tags are discarded.
  - Registered outputs drop in the cycle after `reset` is sampled.
  - Host responses arriving afterwards are treated as unallocated tags.

## Configuration
- `HOST_REQ_TAG_CHECK_EN` defined:
  - An `i_host` handshake whose tag has `free[tag]=1` is consumed (`i_host_r` behaves normally).
  - No `o_rsp_v` is produced, `free` and `o_cnt` are unchanged, and `o_err` is set. `o_err` holds until `reset`.
- Not defined:
  - No check. Every accepted response produces `o_rsp_v` and decrements `o_cnt`.
  - `o_err` is tied to 0.
  - Behaviour with an illegal tag is undefined (no saturation on `o_cnt` underflow).

## Test plan
- Reset: hold `reset` 4 cycles. Require all outputs at their reset values, `i_req_r=0` during reset, and `i_req_r=1` in the first cycle after reset.
- Single request: `sid=17`, `ea=0x100`, `o_host_r=1`. Require `o_host_v` next cycle with `tag=0`, `ea=0x100`, and `o_cnt=1`. Return `tag=0` and require `o_rsp_sid=17` one cycle later, then `o_cnt=0`.
- Full: issue 32 back-to-back requests with sids 0..31. Require tags 0..31 in order, `o_cnt=32`, and `i_req_r=0` on the 33rd. Return tag 5 and require the next request to get tag 5.
- Out-of-order and back-pressure: outstanding tags 0..3 with sids 1,2,3,4. Return tags 3,0,2,1 with `o_rsp_r` low for 2 cycles. Require `i_host_r=0` while `o_rsp_v` is stalled, and sids 4,1,3,2 delivered in order with no loss.
- Illegal tag (macro defined): return tag 9 with none outstanding. Require no `o_rsp_v`, `o_err=1` sticky, and `o_cnt` unchanged.
- Reset mid-operation: 10 outstanding with `o_host_v` stalled, then assert `reset`. Require `o_cnt=0`, `o_host_v=0`, and the first post-reset request gets tag 0.
